// File: rtl/loader_pkg.sv
// Shared types and constants for the disk-to-instruction-memory program loader.
package loader_pkg;

   // Sequencer states of the loader
   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STREAM,
      S_DRAIN,
      S_FINISH
   } state_t;

   // Which terminal pulse FINISH emits
   typedef enum logic [1:0] {
      ST_DONE,
      ST_ERROR,
      ST_ABORTED
   } status_t;

   // Supported disk read latency range, in cycles
   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 4;

   // Width of the transfer length and of the issue/write counters
   localparam int LEN_WIDTH = 16;

   // Keeps the valid pipe depth inside the range the disk can actually have
   function automatic int clamp_latency(input int lat);
      if (lat < LAT_MIN) begin
         return LAT_MIN;
      end
      if (lat > LAT_MAX) begin
         return LAT_MAX;
      end
      return lat;
   endfunction

endpackage

// File: rtl/loader_pipe.sv
// Valid-bit delay line that tracks disk reads in flight, one stage per cycle of read latency.
module loader_pipe #(
   parameter int DEPTH = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic flush,
   input  logic valid_in,
   output logic valid_out,
   output logic empty
);

   // chain[0] is the read issued this cycle, chain[DEPTH] is the read whose data is on hd_data now
   logic [DEPTH:0] chain;

   assign chain[0] = valid_in;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic stage_reg;

         // One delay stage; a flush drops every read still in flight
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               stage_reg <= 1'b0;
            end else if (flush) begin
               stage_reg <= 1'b0;
            end else begin
               stage_reg <= chain[gi];
            end
         end

         assign chain[gi+1] = stage_reg;
      end
   endgenerate

   assign valid_out = chain[DEPTH];
   assign empty     = ~|chain[DEPTH:1];

endmodule

// File: rtl/hd_im_loader.sv
// Copies a contiguous block of disk words into instruction memory while holding the CPU clock.
module hd_im_loader
   import loader_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int HD_ADDR_WIDTH   = 10,
   parameter int IM_ADDR_WIDTH   = 10,
   parameter int HD_READ_LATENCY = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [DATA_WIDTH-1:0] hd_base,
   input  logic [DATA_WIDTH-1:0] im_base,
   input  logic [15:0]           length,
   output logic [DATA_WIDTH-1:0] hd_addr,
   input  logic [DATA_WIDTH-1:0] hd_data,
   output logic [DATA_WIDTH-1:0] im_write_addr,
   output logic [DATA_WIDTH-1:0] im_write_data,
   output logic                  im_write,
   output logic                  busy,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error,
   output logic                  aborted
);

   localparam int PIPE_DEPTH = clamp_latency(HD_READ_LATENCY);
   // Range sums are one bit wider than either operand so they can never wrap
   localparam int HD_SUM_W = ((HD_ADDR_WIDTH > LEN_WIDTH) ? HD_ADDR_WIDTH : LEN_WIDTH) + 1;
   localparam int IM_SUM_W = ((IM_ADDR_WIDTH > LEN_WIDTH) ? IM_ADDR_WIDTH : LEN_WIDTH) + 1;
   localparam logic [HD_SUM_W-1:0] HD_DEPTH = HD_SUM_W'(1) << HD_ADDR_WIDTH;
   localparam logic [IM_SUM_W-1:0] IM_DEPTH = IM_SUM_W'(1) << IM_ADDR_WIDTH;

   state_t                   state_reg, state_next;
   status_t                  status_reg, status_next;
   logic [HD_ADDR_WIDTH-1:0] hd_base_reg;
   logic [IM_ADDR_WIDTH-1:0] im_base_reg;
   logic [LEN_WIDTH-1:0]     len_reg;
   logic [LEN_WIDTH-1:0]     issue_cnt_reg;
   logic [LEN_WIDTH-1:0]     write_cnt_reg;
   logic                     im_write_reg;
   logic [IM_ADDR_WIDTH-1:0] im_addr_reg;
   logic [DATA_WIDTH-1:0]    im_data_reg;

   logic                     accept;
   logic                     active;
   logic                     moving;
   logic                     pipe_in;
   logic                     pipe_flush;
   logic                     pipe_out;
   logic                     pipe_empty;
   logic                     write_now;
   logic                     range_bad;
   logic [HD_SUM_W-1:0]      hd_sum;
   logic [IM_SUM_W-1:0]      im_sum;
   logic [HD_ADDR_WIDTH-1:0] hd_rd_addr;
   logic                     unused_bits;

   // Only the low address bits of the bases are meaningful
   assign unused_bits = ^{hd_base, im_base};

   // FINISH behaves like IDLE for a new request, so back-to-back transfers lose no cycle
   assign accept     = ((state_reg == S_IDLE) || (state_reg == S_FINISH)) && start;
   assign active     = (state_reg == S_SETUP) || (state_reg == S_STREAM) || (state_reg == S_DRAIN);
   assign moving     = (state_reg == S_STREAM) || (state_reg == S_DRAIN);
   assign pipe_in    = (state_reg == S_STREAM) && !abort;
   assign pipe_flush = active && abort;
   assign write_now  = pipe_out && moving && !abort;

   assign hd_sum    = HD_SUM_W'(hd_base_reg) + HD_SUM_W'(len_reg);
   assign im_sum    = IM_SUM_W'(im_base_reg) + IM_SUM_W'(len_reg);
   assign range_bad = (hd_sum > HD_DEPTH) || (im_sum > IM_DEPTH);

   assign hd_rd_addr = hd_base_reg + HD_ADDR_WIDTH'(issue_cnt_reg);

   loader_pipe #(
      .DEPTH(PIPE_DEPTH)
   ) u_pipe (
      .clock    (clock),
      .reset    (reset),
      .flush    (pipe_flush),
      .valid_in (pipe_in),
      .valid_out(pipe_out),
      .empty    (pipe_empty)
   );

   // State and terminal-status registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg  <= S_IDLE;
         status_reg <= ST_DONE;
      end else begin
         state_reg  <= state_next;
         status_reg <= status_next;
      end
   end

   // Next-state logic; abort outranks every other exit from an active state
   always_comb begin
      state_next  = state_reg;
      status_next = status_reg;
      case (state_reg)
         S_IDLE, S_FINISH: begin
            if (start) begin
               state_next  = S_SETUP;
               status_next = ST_DONE;
            end else begin
               state_next = S_IDLE;
            end
         end
         S_SETUP: begin
            if (abort) begin
               state_next  = S_FINISH;
               status_next = ST_ABORTED;
            end else if (len_reg == '0) begin
               state_next  = S_FINISH;
               status_next = ST_DONE;
            end else if (range_bad) begin
               state_next  = S_FINISH;
               status_next = ST_ERROR;
            end else begin
               state_next = S_STREAM;
            end
         end
         S_STREAM: begin
            if (abort) begin
               state_next  = S_FINISH;
               status_next = ST_ABORTED;
            end else if (issue_cnt_reg == len_reg - LEN_WIDTH'(1)) begin
               state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (abort) begin
               state_next  = S_FINISH;
               status_next = ST_ABORTED;
            end else if (pipe_empty && (write_cnt_reg == len_reg)) begin
               state_next  = S_FINISH;
               status_next = ST_DONE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Request latch, read/write counters and the registered IM write port
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hd_base_reg   <= '0;
         im_base_reg   <= '0;
         len_reg       <= '0;
         issue_cnt_reg <= '0;
         write_cnt_reg <= '0;
         im_write_reg  <= 1'b0;
         im_addr_reg   <= '0;
         im_data_reg   <= '0;
      end else begin
         im_write_reg <= write_now;
         if (accept) begin
            hd_base_reg   <= hd_base[HD_ADDR_WIDTH-1:0];
            im_base_reg   <= im_base[IM_ADDR_WIDTH-1:0];
            len_reg       <= length;
            issue_cnt_reg <= '0;
            write_cnt_reg <= '0;
         end
         if ((state_reg == S_STREAM) && !abort) begin
            issue_cnt_reg <= issue_cnt_reg + LEN_WIDTH'(1);
         end
         if (write_now) begin
            im_data_reg   <= hd_data;
            im_addr_reg   <= im_base_reg + IM_ADDR_WIDTH'(write_cnt_reg);
            write_cnt_reg <= write_cnt_reg + LEN_WIDTH'(1);
         end
      end
   end

   assign hd_addr       = DATA_WIDTH'(hd_rd_addr);
   assign im_write_addr = DATA_WIDTH'(im_addr_reg);
   assign im_write_data = im_data_reg;
   assign im_write      = im_write_reg;
   assign busy          = active;
   assign cpu_hold      = active;
   assign done          = (state_reg == S_FINISH) && (status_reg == ST_DONE);
   assign error         = (state_reg == S_FINISH) && (status_reg == ST_ERROR);
   assign aborted       = (state_reg == S_FINISH) && (status_reg == ST_ABORTED);

endmodule

// File: tb/tb_hd_im_loader.sv
// Bench: two loaders (read latency 1 and 3) share stimulus and are checked cycle by cycle.
module tb_hd_im_loader;

   localparam int DW       = 32;
   localparam int HD_DEPTH = 1024;

   logic          clock   = 1'b0;
   logic          reset   = 1'b0;
   logic          start   = 1'b0;
   logic          abort   = 1'b0;
   logic [DW-1:0] hd_base = '0;
   logic [DW-1:0] im_base = '0;
   logic [15:0]   length  = '0;

   logic [DW-1:0] hd_addr1, hd_data1, im_write_addr1, im_write_data1;
   logic          im_write1, busy1, cpu_hold1, done1, error1, aborted1;
   logic [DW-1:0] hd_addr3, hd_data3, im_write_addr3, im_write_data3;
   logic          im_write3, busy3, cpu_hold3, done3, error3, aborted3;

   logic [DW-1:0] disk [HD_DEPTH];
   logic [9:0]    lat1_addr;
   logic [9:0]    lat3_addr [3];

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   // Disk read ports: data appears L cycles after the address is presented
   always @(posedge clock) begin
      lat1_addr    <= hd_addr1[9:0];
      lat3_addr[0] <= hd_addr3[9:0];
      lat3_addr[1] <= lat3_addr[0];
      lat3_addr[2] <= lat3_addr[1];
   end
   assign hd_data1 = disk[lat1_addr];
   assign hd_data3 = disk[lat3_addr[2]];

   hd_im_loader #(.DATA_WIDTH(32), .HD_ADDR_WIDTH(10), .IM_ADDR_WIDTH(10), .HD_READ_LATENCY(1)) u_l1 (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .hd_base(hd_base), .im_base(im_base), .length(length),
      .hd_addr(hd_addr1), .hd_data(hd_data1),
      .im_write_addr(im_write_addr1), .im_write_data(im_write_data1), .im_write(im_write1),
      .busy(busy1), .cpu_hold(cpu_hold1), .done(done1), .error(error1), .aborted(aborted1)
   );

   hd_im_loader #(.DATA_WIDTH(32), .HD_ADDR_WIDTH(10), .IM_ADDR_WIDTH(10), .HD_READ_LATENCY(3)) u_l3 (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .hd_base(hd_base), .im_base(im_base), .length(length),
      .hd_addr(hd_addr3), .hd_data(hd_data3),
      .im_write_addr(im_write_addr3), .im_write_data(im_write_data3), .im_write(im_write3),
      .busy(busy3), .cpu_hold(cpu_hold3), .done(done3), .error(error3), .aborted(aborted3)
   );

   // Reference: what a transfer started at edge 0 looks like in cycle n.
   // Packed as {busy, cpu_hold, done, error, aborted, im_write, addr[31:0], data[31:0]}.
   function automatic logic [69:0] expect_vec(input int lat, input int n, input int hb,
                                              input int ib, input int len, input int a_edge);
      logic          b, d, e, a, w;
      logic [31:0]   wa, wd;
      int            fin, k;
      bit            bad, abt;
      b = 1'b0; d = 1'b0; e = 1'b0; a = 1'b0; w = 1'b0; wa = '0; wd = '0;
      bad = (hb + len > HD_DEPTH) || (ib + len > HD_DEPTH);
      if (len == 0 || bad) begin
         b = (n == 1);
         d = (n == 2) && (len == 0);
         e = (n == 2) && (len != 0);
      end else begin
         fin = 3 + lat + len;
         abt = (a_edge >= 1) && (a_edge <= fin - 1);
         if (abt) fin = a_edge + 1;
         b = (n >= 1) && (n < fin);
         d = (n == fin) && !abt;
         a = (n == fin) && abt;
         k = n - 3 - lat;
         if (k >= 0 && k < len && n < fin) begin
            w  = 1'b1;
            wa = 32'(ib + k);
            wd = disk[hb + k];
         end
      end
      return {b, b, d, e, a, w, wa, wd};
   endfunction

   function automatic logic [203:0] all_outs();
      return {hd_addr1, im_write_addr1, im_write_data1, im_write1, busy1, cpu_hold1, done1, error1, aborted1,
              hd_addr3, im_write_addr3, im_write_data3, im_write3, busy3, cpu_hold3, done3, error3, aborted3};
   endfunction

   task automatic check_cycle(input int n, input int hb, input int ib, input int len, input int a_edge);
      logic [69:0] e1, e3, o1, o3;
      e1 = expect_vec(1, n, hb, ib, len, a_edge);
      e3 = expect_vec(3, n, hb, ib, len, a_edge);
      o1 = {busy1, cpu_hold1, done1, error1, aborted1, im_write1,
            e1[64] ? {im_write_addr1, im_write_data1} : 64'd0};
      o3 = {busy3, cpu_hold3, done3, error3, aborted3, im_write3,
            e3[64] ? {im_write_addr3, im_write_data3} : 64'd0};
      tests++;
      assert (o1 === e1) else begin
         fails++;
         $error("FAIL lat1 cycle %0d: got %h, expected %h", n, o1, e1);
      end
      tests++;
      assert (o3 === e3) else begin
         fails++;
         $error("FAIL lat3 cycle %0d: got %h, expected %h", n, o3, e3);
      end
   endtask

   task automatic check_quiet(input int id);
      logic [11:0] o;
      o = {busy1, cpu_hold1, done1, error1, aborted1, im_write1,
           busy3, cpu_hold3, done3, error3, aborted3, im_write3};
      tests++;
      assert (o === 12'd0) else begin
         fails++;
         $error("FAIL idle_%0d: got %h, expected 000", id, o);
      end
   endtask

   task automatic check_zero(input int id);
      logic [203:0] o;
      o = all_outs();
      tests++;
      assert (o === 204'd0) else begin
         fails++;
         $error("FAIL reset_outs_%0d: got %h, expected 0", id, o);
      end
   endtask

   // One transfer: start sampled at edge 0, then checked every cycle until both loaders are idle.
   // a_edge / sb_edge: edge at which abort / a stray start are sampled (-1 = never).
   task automatic run_xfer(input logic [31:0] hb, input logic [31:0] ib, input int len,
                           input int a_edge, input int sb_edge);
      int hbi, ibi, ncyc;
      hbi  = int'(hb[9:0]);
      ibi  = int'(ib[9:0]);
      ncyc = 9 + len;
      @(negedge clock);
      hd_base = hb;
      im_base = ib;
      length  = 16'(len);
      start   = 1'b1;
      @(posedge clock);
      #1;
      start   = 1'b0;
      hd_base = $urandom;
      im_base = $urandom;
      length  = 16'($urandom);
      for (int n = 1; n <= ncyc; n++) begin
         @(negedge clock);
         check_cycle(n, hbi, ibi, len, a_edge);
         abort = (n == a_edge);
         start = (n == sb_edge);
      end
      abort = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < HD_DEPTH; i++) disk[i] = $urandom;
      disk[16] = 32'hA0A0_0001;
      disk[17] = 32'hB0B0_0002;
      disk[18] = 32'hC0C0_0003;
      disk[19] = 32'hD0D0_0004;

      // Reset state
      repeat (2) @(posedge clock);
      #1 check_zero(0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_quiet(0);

      // Basic copy
      run_xfer(32'h10, 32'h20, 4, -1, -1);
      // Zero length, range errors, exact-fit boundaries
      run_xfer(32'h55, 32'h66, 0, -1, -1);
      run_xfer(32'd1020, 32'd0, 8, -1, -1);
      run_xfer(32'd0, 32'd1020, 8, -1, -1);
      run_xfer(32'd1016, 32'd1016, 8, -1, -1);
      // Abort mid-stream, and abort on the edge of the final write
      run_xfer(32'h100, 32'h200, 16, 7, -1);
      run_xfer(32'h40, 32'h80, 4, 7, -1);
      // Latency sweep
      run_xfer(32'h30, 32'h300, 5, -1, -1);
      // Stray start while busy
      run_xfer(32'h50, 32'h150, 6, -1, 3);

      // Abort while idle does nothing
      @(negedge clock);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      check_quiet(1);

      // Reset during the cycle-5 write
      @(negedge clock);
      hd_base = 32'h10; im_base = 32'h20; length = 16'd4; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clock);
         check_cycle(n, 16, 32, 4, -1);
      end
      #1 reset = 1'b0;
      #1 check_zero(1);
      @(posedge clock);
      #1 check_zero(2);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_quiet(2);
      run_xfer(32'h10, 32'h20, 4, -1, -1);

      // Randomized transfers
      for (int t = 0; t < 12; t++) begin
         logic [31:0] hb, ib;
         int          len, a_edge;
         len = $urandom_range(0, 12);
         hb  = $urandom;
         ib  = $urandom;
         if ($urandom_range(0, 3) == 0) hb[9:0] = 10'(HD_DEPTH - $urandom_range(1, 14));
         if ($urandom_range(0, 5) == 0) ib[9:0] = 10'(HD_DEPTH - $urandom_range(1, 14));
         a_edge = ($urandom_range(0, 1) == 1) ? $urandom_range(2, len + 6) : -1;
         run_xfer(hb, ib, len, a_edge, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
